// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver: scans NUM_DIGITS active-low digit strobes,
// snapshotting the inputs once per frame and decoding hex, decimal points and leading zeros.
module seven_seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] nums,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_en,
  input  logic                    blank_lz,
  output logic [6:0]              display,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic                    frame_start
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [4*NUM_DIGITS-1:0]   sh_nums;
  logic [NUM_DIGITS-1:0]     sh_dp;
  logic                      sh_hex;
  logic                      sh_blz;

  logic                      tick;
  logic                      frame_tick;
  logic [IW-1:0]             next_idx;
  logic [4*NUM_DIGITS-1:0]   cur_nums;
  logic [NUM_DIGITS-1:0]     cur_dp;
  logic                      cur_hex;
  logic                      cur_blz;
  logic [3:0]                nib;
  logic                      upper_zero;
  logic [6:0]                seg_next;
  logic [NUM_DIGITS-1:0]     digit_next;
  logic                      dp_next;

  function automatic logic [6:0] decode(input logic [3:0] n, input logic hex);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b0000011;
      4'hc: s = 7'b1000110;
      4'hd: s = 7'b0100001;
      4'he: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    if (!hex && n > 4'h9) s = 7'b1111111;
    return s;
  endfunction

  assign tick = (cnt == LAST_CNT);

  always_comb begin
    frame_tick = tick && (idx == LAST_IDX);
    next_idx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    // On the frame-start edge the outputs must reflect the values being captured now.
    cur_nums   = frame_tick ? nums     : sh_nums;
    cur_dp     = frame_tick ? dp_in    : sh_dp;
    cur_hex    = frame_tick ? hex_en   : sh_hex;
    cur_blz    = frame_tick ? blank_lz : sh_blz;
    nib        = cur_nums[4*int'(next_idx) +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(next_idx) && cur_nums[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    seg_next = decode(nib, cur_hex);
    if (cur_blz && next_idx != '0 && upper_zero) seg_next = 7'b1111111;
    digit_next = ~(NUM_DIGITS'(1) << next_idx);
    dp_next    = ~cur_dp[next_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= LAST_IDX;
      sh_nums     <= '0;
      sh_dp       <= '0;
      sh_hex      <= 1'b0;
      sh_blz      <= 1'b0;
      display     <= 7'b1111111;
      dp          <= 1'b1;
      digit       <= '1;
      frame_start <= 1'b0;
    end else begin
      cnt         <= tick ? '0 : cnt + 1'b1;
      frame_start <= frame_tick;
      if (frame_tick) begin
        sh_nums <= nums;
        sh_dp   <= dp_in;
        sh_hex  <= hex_en;
        sh_blz  <= blank_lz;
      end
      if (tick) begin
        idx     <= next_idx;
        display <= seg_next;
        dp      <= dp_next;
        digit   <= digit_next;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan (4 digits, 4 clocks per slot): expected slot
// contents are queued when inputs are driven and checked at every scan tick.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int TD = 4;

  logic          clk;
  logic          rst;
  logic [15:0]   nums;
  logic [3:0]    dp_in;
  logic          hex_en;
  logic          blank_lz;
  logic [6:0]    display;
  logic          dp;
  logic [3:0]    digit;
  logic          frame_start;

  int total = 0;
  int bad   = 0;

  // Entry layout: {frame_start, digit[3:0], display[6:0], dp}
  logic [12:0] exp_q[$];
  logic [12:0] last_exp;
  localparam logic [12:0] DARK = {1'b0, 4'b1111, 7'b1111111, 1'b1};

  seven_seg_scan #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .nums(nums), .dp_in(dp_in), .hex_en(hex_en),
    .blank_lz(blank_lz), .display(display), .dp(dp), .digit(digit),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n, input logic hex);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'ha: return hex ? 7'b0001000 : 7'b1111111;
      4'hb: return hex ? 7'b0000011 : 7'b1111111;
      4'hc: return hex ? 7'b1000110 : 7'b1111111;
      4'hd: return hex ? 7'b0100001 : 7'b1111111;
      4'he: return hex ? 7'b0000110 : 7'b1111111;
      default: return hex ? 7'b0001110 : 7'b1111111;
    endcase
  endfunction

  // Queue one full frame built from the inputs currently being driven.
  task automatic push_frame();
    logic [6:0]  s;
    logic [15:0] up;
    for (int i = 0; i < ND; i++) begin
      s  = seg_of(nums[4*i +: 4], hex_en);
      up = nums >> (4*i);
      if (blank_lz && i >= 1 && up == 16'h0) s = 7'b1111111;
      exp_q.push_back({(i == 0), ~(4'b0001 << i), s, ~dp_in[i]});
    end
  endtask

  task automatic compare(input string tag, input logic [12:0] obs, input logic [12:0] req);
    total++;
    assert (obs === req)
      else begin
        bad++;
        $error("FAIL %s observed=%b required=%b", tag, obs, req);
      end
  endtask

  // Entered 1ns after a tick (or reset) edge; leaves 1ns after the next tick edge.
  task automatic check_slot(input string tag);
    logic [12:0] e;
    @(posedge clk); #1;
    compare({tag, "_hold"}, {frame_start, digit, display, dp}, {1'b0, last_exp[11:0]});
    repeat (TD - 1) @(posedge clk);
    #1;
    total++;
    assert (exp_q.size() != 0)
      else begin
        bad++;
        $error("FAIL %s_queue observed=empty required=entry", tag);
      end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      compare(tag, {frame_start, digit, display, dp}, e);
      last_exp = e;
    end
  endtask

  task automatic run_frame(input string tag);
    for (int k = 0; k < ND; k++) check_slot(tag);
  endtask

  initial begin
    rst      = 1'b1;
    nums     = 16'h0001;
    dp_in    = 4'b0000;
    hex_en   = 1'b0;
    blank_lz = 1'b0;
    last_exp = DARK;
    repeat (3) @(posedge clk);
    #1;
    compare("reset_state", {frame_start, digit, display, dp}, DARK);
    rst = 1'b0;

    push_frame();
    run_frame("first_frame");

    nums = 16'h1234;
    push_frame();
    run_frame("scan_1234");
    push_frame();
    run_frame("scan_1234_repeat");

    push_frame();
    check_slot("snapshot_old");
    check_slot("snapshot_old");
    nums = 16'h5678;
    check_slot("snapshot_old");
    check_slot("snapshot_old");
    push_frame();
    run_frame("snapshot_new");

    blank_lz = 1'b1;
    nums = 16'h0050;
    push_frame();
    run_frame("blank_0050");
    nums = 16'h0000;
    push_frame();
    run_frame("blank_0000");

    blank_lz = 1'b0;
    nums   = 16'habcd;
    hex_en = 1'b1;
    push_frame();
    run_frame("hex_on");
    hex_en = 1'b0;
    push_frame();
    run_frame("hex_off");

    nums   = 16'h1234;
    hex_en = 1'b1;
    dp_in  = 4'b0100;
    push_frame();
    run_frame("dp_digit2");

    dp_in = 4'b0000;
    nums  = 16'h9876;
    push_frame();
    check_slot("pre_reset");
    check_slot("pre_reset");
    check_slot("pre_reset");
    rst = 1'b1;
    @(posedge clk); #1;
    compare("mid_reset", {frame_start, digit, display, dp}, DARK);
    rst = 1'b0;
    void'(exp_q.pop_back());
    last_exp = DARK;
    push_frame();
    run_frame("after_reset");

    total++;
    assert (exp_q.size() == 0)
      else begin
        bad++;
        $error("FAIL queue_drained observed=%0d required=0", exp_q.size());
      end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed seven-segment display driver for N digits. It divides the system clock into a scan tick and cycles an active-low digit strobe across the digits. Input values are snapshotted once per frame so the display never shows a partial update. It adds hex decoding, per-digit decimal points, optional leading-zero blanking and a frame-start strobe, and it sits between the cart's status or sensor-value logic and the board's common-anode display pins.

## Interface
Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (legal 1..8)
- TICK_DIV, 65536, clk cycles per digit slot (legal ≥ 2)

Ports:
- clk  input  1  system clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- nums  input  4*NUM_DIGITS  digit nibbles; nums[3:0] = digit 0 (rightmost)
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit
- hex_en  input  1  1: nibbles 10–15 display A,b,C,d,E,F; 0: they display blank
- blank_lz  input  1  1: suppress leading zeros
- display  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
- dp  output  1  decimal point, active-low, registered
- digit  output  NUM_DIGITS  digit enables, active-low one-hot, registered
- frame_start  output  1  one-cycle pulse when digit 0 becomes active

## Operation
- Reset is synchronous and active-high. One clock domain; no derived or gated clocks. clk_divider-style ripple clocking is forbidden; the tick is a clock enable.
- Divider: cnt counts 0..TICK_DIV-1 and wraps. tick = (cnt == TICK_DIV-1).
- Scan index idx resets to NUM_DIGITS-1. On each tick, idx advances, wrapping from NUM_DIGITS-1 to 0.
- Frame start is a tick on which idx wraps to 0. On that edge, the shadow registers capture nums, dp_in, hex_en and blank_lz. Outputs loaded on the same edge use the freshly captured values.
- On every tick edge, the outputs are loaded for the new idx:
  - digit has bit idx low and all other bits high.
  - display = decode(shadow nibble idx).
  - dp = ~shadow_dp[idx].
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - When hex_en=0, nibbles 10–15 decode to 1111111.
- Leading-zero blanking: digit i (i ≥ 1) is blanked (display = 1111111) when blank_lz=1 and nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked. dp is unaffected by blanking.
- Between ticks, all outputs hold.
- Input changes mid-frame are invisible until the next frame start.

## Timing
- Reset values: cnt=0, idx=NUM_DIGITS-1, shadows=0.
- Reset output values: digit all ones (display dark), display=1111111, dp=1, frame_start=0.
- First tick occurs TICK_DIV cycles after the first clk edge with rst low. That edge is a frame start; digit 0 is driven from the nums value sampled on that edge.
- Each digit is active for exactly TICK_DIV cycles. Frame period is NUM_DIGITS*TICK_DIV cycles.
- frame_start is high for the one cycle following the frame-start edge. It is low otherwise, including during reset.
- NUM_DIGITS=1: every tick is a frame start; digit is held at 0 after the first tick; frame_start pulses every TICK_DIV cycles.
- rst asserted mid-frame: on the next edge, all state returns to reset values and the display goes dark; the scan restarts from the first tick.
- rst has priority over tick on the same edge.

## Test plan
Bench uses NUM_DIGITS=4, TICK_DIV=4.
- Reset release with nums=16'h0001 -> digit=1111 and display=1111111 for 4 cycles; then digit=1110, display=1111001, frame_start=1 for one cycle.
- Scan order with nums=16'h1234, blank_lz=0 -> digit 1110/1101/1011/0111 with display 0011001/0110000/0100100/1111001, each held 4 cycles, repeating every 16 cycles.
- Snapshot: change nums from 16'h1234 to 16'h5678 while digit=1101 -> remaining slots still show 2 and 1; the next frame shows 8,7,6,5.
- Leading-zero blanking with blank_lz=1:
  - nums=16'h0050 -> digits 3 and 2 show 1111111, digit 1 shows 0010010, digit 0 shows 1000000.
  - nums=16'h0000 -> only digit 0 is lit, showing 1000000.
- Hex and decimal point:
  - nums=16'hABCD, hex_en=1 -> digits 0..3 show 0100001, 1000110, 0000011, 0001000.
  - Same value with hex_en=0 -> all four show 1111111.
  - dp_in=4'b0100 -> dp=0 only while digit=1011.
- Mid-operation reset: pulse rst for one cycle while digit=1011 -> the next cycle shows digit=1111 and display=1111111; digit 0 reappears exactly 4 cycles after rst falls, with a frame_start pulse.
